rtmc_spi_xfer: RTL and testbench
================================

# rtmc_spi_xfer

Parametrised SPI slave transceiver, successor to the byte-only SPI shifter. It adds a configurable word width, all four CPOL/CPHA modes and a bit-order option. Each direction has a small synchronous FIFO with valid/ready handshakes. It also synchronises the SPI pins and reports overflow and underflow. It sits between the chip pins and the command decoder.

## Interface
- N_BITS, 8: word width in bits, ≥2.
- FIFO_DEPTH, 4: entries per FIFO, power of two, ≥2.
- LSB_FIRST, 0: 0 shifts MSB first, 1 shifts LSB first (both directions).
- TX_IDLE, 0: N_BITS word sent when tx FIFO is empty.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  {CPOL, CPHA}; latched only while synced cs_n is high.
- sck, cs_n, sdi  in  1 each  SPI pins (asynchronous).
- sdo  out  1  serial out; 0 when deselected.
- sdo_oe  out  1  synced ~cs_n; pad output enable.
- tx_data  in  N_BITS  word to send.
- tx_valid  in  1  request to push tx_data.
- tx_ready  out  1  tx FIFO not full.
- rx_data  out  N_BITS  head of rx FIFO.
- rx_valid  out  1  rx FIFO not empty.
- rx_ready  in  1  request to pop rx FIFO.
- tx_level, rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- rx_overflow, tx_underflow  out  1  sticky error flags.
- clr_flags  in  1  clears both sticky flags.

## Operation
- sck, cs_n and sdi each pass through 2-flop synchronisers. sck gets a third delay flop for edge detection.
- Leading edge is the first transition away from CPOL. CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- Each sample shifts synced sdi into the rx register and increments bit_cnt (0..N_BITS-1).
- On the N_BITS-th sample, the word is pushed to the rx FIFO and bit_cnt wraps to 0.
- If the rx FIFO is full and rx_ready is low that cycle, the word is dropped and rx_overflow is set.
- Tx load points:
  - CPHA=0: the cycle synced cs_n falls, and each trailing edge that follows a word-completing sample.
  - CPHA=1: each leading edge with bit_cnt=0; the loaded word's first bit drives sdo directly.
- At a load point the tx FIFO head is popped. If the FIFO is empty, TX_IDLE is loaded and tx_underflow is set.
- Other shift edges advance the tx register by one bit. sdo is the MSB (or LSB if LSB_FIRST) of the tx register.
- Synced cs_n high:
  - bit_cnt=0; the partial rx word is discarded.
  - The tx register clears and sdo=0.
  - mode is re-latched.
  - A popped but unsent tx word is lost.
- FIFOs:
  - Push and pop in the same cycle are both accepted, including when full (rx) or empty-bypass-free (tx). A full FIFO accepts a push when a pop occurs the same cycle.
  - An empty FIFO does not bypass: data pushed is visible the next cycle.
- Host side: push happens when tx_valid && tx_ready. Pop happens when rx_valid && rx_ready. Pointers wrap modulo FIFO_DEPTH.
- clr_flags takes priority over a same-cycle set; the flags stay cleared for that cycle.
- Reset values:
  - All synchronisers 1 for cs_n, CPOL-independent 0 for sck/sdi.
  - FIFOs empty; levels 0.
  - tx_ready=1, rx_valid=0, rx_data=0.
  - sdo=0, sdo_oe=0, both flags 0.
  - Latched mode=00.
- Asserting rst mid-transfer aborts immediately. Transfers restart only after cs_n is seen high then low.

## Timing
- SCK pin edge to detected edge: 3 clk. sdo updates 1 clk after the detected edge (4 clk from pin).
- Requirements on the master: SCK half-period ≥ 5 clk (≤ clk/10), and cs_n setup ≥ 4 clk before the first sck edge.
- Rx latency: the last sampled sck pin edge reaches rx_valid in 5 clk (3 sync/detect, 1 shift/push, 1 FIFO register).
- tx_ready and rx_valid are registered and change the cycle after a push or pop.
- Levels update the cycle after the event.

## Test plan
- Mode 0, N_BITS=8: push 0xA5 and send 0x3C on sdi → rx_data=0x3C with rx_valid. sdo carries bits 1,0,1,0,0,1,0,1, and tx_level returns to 0.
- Repeat for modes 1, 2 and 3 with two back-to-back words 0x81 and 0x7E under a single cs_n → both received in order, sdo correct in every mode.
- Send FIFO_DEPTH+1 words with rx_ready=0 → rx_level=4, rx_overflow=1, first four words intact. clr_flags → flag 0.
- Empty tx FIFO, 1 word clocked → sdo carries TX_IDLE=0x00 and tx_underflow=1.
- cs_n deasserted after 3 bits → no rx push, bit_cnt reset. The next full word is received correctly.
- rst asserted mid-word with tx_level=2 → all outputs at reset values the next cycle, tx_level=0, no spurious rx_valid.

Source files
------------

// File: rtl/rtmc_spi_xfer.sv
// SPI slave transceiver: synchronised pins, all four CPOL/CPHA modes, configurable
// word width and bit order, with small rx/tx FIFOs and sticky overflow/underflow flags.
module rtmc_spi_xfer #(
  parameter int                N_BITS     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter bit                LSB_FIRST  = 1'b0,
  parameter logic [N_BITS-1:0] TX_IDLE    = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    mode_i,
  input  logic                          sck_i,
  input  logic                          cs_n_i,
  input  logic                          sdi_i,
  output logic                          sdo_o,
  output logic                          sdo_oe_o,
  input  logic [N_BITS-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [N_BITS-1:0]             rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level_o,
  output logic                          rx_overflow_o,
  output logic                          tx_underflow_o,
  input  logic                          clr_flags_i
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BC_W    = $clog2(N_BITS);
  localparam int OUT_BIT = LSB_FIRST ? 0 : N_BITS - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(N_BITS - 1);

  logic [2:0]        sck_q;
  logic [1:0]        cs_q;
  logic [1:0]        sdi_q;
  logic [1:0]        init_q;
  logic              armed_q;
  logic              sel_prev_q;
  logic [1:0]        mode_q;
  logic              lead_q;
  logic              trail_q;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [N_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [N_BITS-1:0] tx_sr_q, tx_sr_d;
  logic              push_q;
  logic [N_BITS-1:0] push_word_q;

  logic [N_BITS-1:0] tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_q, tx_rd_q;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              tx_ready_q;
  logic [N_BITS-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rx_wr_q, rx_rd_q;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              rx_valid_q;
  logic              rx_ovf_q, tx_unf_q;

  logic cs_s, sdi_s, sel, cs_fall, sck_edge, lead_det, trail_det;
  logic sample, shift, tx_load, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_pop, rx_push, ovf_set, unf_set;
  logic [N_BITS-1:0] tx_head;

  // Transfers are only honoured once cs_n has been seen high after reset.
  assign cs_s      = cs_q[1];
  assign sdi_s     = sdi_q[1];
  assign sel       = armed_q & ~cs_s;
  assign cs_fall   = sel & ~sel_prev_q;
  assign sck_edge  = sck_q[1] ^ sck_q[2];
  assign lead_det  = sel & sck_edge & (sck_q[1] ^ mode_q[1]);
  assign trail_det = sel & sck_edge & ~(sck_q[1] ^ mode_q[1]);

  assign sample  = mode_q[0] ? trail_q : lead_q;
  assign shift   = mode_q[0] ? lead_q : trail_q;
  // A shift edge with bit_cnt=0 is either the CPHA=1 leading edge of a new word
  // or the CPHA=0 trailing edge right after a completed word.
  assign tx_load = sel & ((~mode_q[0] & cs_fall) | (shift & (bit_cnt_q == '0)));

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_empty ? TX_IDLE : tx_mem_q[tx_rd_q];
  assign tx_push  = tx_valid_i & tx_ready_q;
  assign tx_pop   = tx_load & ~tx_empty;
  assign unf_set  = tx_load & tx_empty;
  assign tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);

  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_pop   = rx_valid_q & rx_ready_i;
  assign rx_push  = push_q & (~rx_full | rx_pop);
  assign ovf_set  = push_q & rx_full & ~rx_pop;
  assign rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    if (!sel) begin
      bit_cnt_d = '0;
      tx_sr_d   = '0;
    end else begin
      if (sample) begin
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        rx_sr_d   = LSB_FIRST ? {sdi_s, rx_sr_q[N_BITS-1:1]} : {rx_sr_q[N_BITS-2:0], sdi_s};
      end
      if (tx_load) begin
        tx_sr_d = tx_head;
      end else if (shift) begin
        tx_sr_d = LSB_FIRST ? (tx_sr_q >> 1) : (tx_sr_q << 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q      <= '0;
      cs_q       <= '1;
      sdi_q      <= '0;
      init_q     <= '0;
      armed_q    <= 1'b0;
      sel_prev_q <= 1'b0;
      mode_q     <= '0;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      bit_cnt_q  <= '0;
      push_q     <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b1;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_unf_q   <= 1'b0;
    end else begin
      // Stage 0: pin synchronisers and edge detection
      sck_q      <= {sck_q[1:0], sck_i};
      cs_q       <= {cs_q[0], cs_n_i};
      sdi_q      <= {sdi_q[0], sdi_i};
      init_q     <= {init_q[0], 1'b1};
      if (init_q[1] && cs_s) armed_q <= 1'b1;
      sel_prev_q <= sel;
      if (cs_s) mode_q <= mode_i;
      lead_q     <= lead_det;
      trail_q    <= trail_det;
      // Stage 1: shift registers and word completion
      bit_cnt_q  <= bit_cnt_d;
      push_q     <= sel & sample & (bit_cnt_q == LAST_BIT);
      // Stage 2: FIFO bookkeeping
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      tx_cnt_q   <= tx_cnt_d;
      tx_ready_q <= (tx_cnt_d != FULL_CNT);
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      rx_cnt_q   <= rx_cnt_d;
      rx_valid_q <= (rx_cnt_d != '0);
      rx_ovf_q   <= clr_flags_i ? 1'b0 : (rx_ovf_q | ovf_set);
      tx_unf_q   <= clr_flags_i ? 1'b0 : (tx_unf_q | unf_set);
    end
  end

  always_ff @(posedge clk_i) begin
    rx_sr_q     <= rx_sr_d;
    tx_sr_q     <= tx_sr_d;
    push_word_q <= rx_sr_d;
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data_i;
    if (rx_push) rx_mem_q[rx_wr_q] <= push_word_q;
  end

  assign sdo_o          = sel & tx_sr_q[OUT_BIT];
  assign sdo_oe_o       = ~cs_s;
  assign tx_ready_o     = tx_ready_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_data_o      = rx_valid_q ? rx_mem_q[rx_rd_q] : '0;
  assign tx_level_o     = tx_cnt_q;
  assign rx_level_o     = rx_cnt_q;
  assign rx_overflow_o  = rx_ovf_q;
  assign tx_underflow_o = tx_unf_q;

endmodule

// File: tb/tb_rtmc_spi_xfer.sv
// Directed bench for rtmc_spi_xfer: bench acts as SPI master and host, with
// queue scoreboards for the words expected on sdo and on rx_data.
module tb_rtmc_spi_xfer;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       sck, cs_n, sdi;
  logic       sdo, sdo_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] tx_level, rx_level;
  logic       rx_overflow, tx_underflow, clr_flags;

  int total = 0;
  int bad   = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [1:0] md;

  rtmc_spi_xfer dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sck_i(sck), .cs_n_i(cs_n), .sdi_i(sdi),
    .sdo_o(sdo), .sdo_oe_o(sdo_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready), .tx_level_o(tx_level), .rx_level_o(rx_level),
    .rx_overflow_o(rx_overflow), .tx_underflow_o(tx_underflow), .clr_flags_i(clr_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    md = m; mode = m; sck = m[1];
    wclk(6);
  endtask

  task automatic host_push(input logic [7:0] v);
    tx_data = v; tx_valid = 1'b1;
    wclk(1);
    tx_valid = 1'b0;
    txq.push_back(v);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; wclk(1);
    clr_flags = 1'b0; wclk(1);
  endtask

  task automatic cs_low();
    cs_n = 1'b0; wclk(8);
  endtask

  task automatic cs_high();
    wclk(H); cs_n = 1'b1; wclk(8);
  endtask

  // One master word (MSB first); sdo sampled just before each master sampling edge.
  task automatic xfer(input logic [7:0] mosi, input int nbits, input bit lat_chk);
    logic [7:0] exp, got;
    exp = (txq.size() > 0) ? txq.pop_front() : 8'h00;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!md[0]) begin
        sdi = mosi[7-i];
        wclk(H);
        got = {got[6:0], sdo};
        sck = ~md[1];
        if (lat_chk && i == nbits - 1) begin
          wclk(4); chk("rx_valid_lat4", rx_valid, 1'b0);
          wclk(1); chk("rx_valid_lat5", rx_valid, 1'b1);
          wclk(H - 5);
        end else begin
          wclk(H);
        end
        sck = md[1];
      end else begin
        sck = ~md[1];
        sdi = mosi[7-i];
        wclk(H);
        got = {got[6:0], sdo};
        sck = md[1];
        wclk(H);
      end
    end
    if (nbits == 8) begin
      chk("sdo_word", got, exp);
      rxq.push_back(mosi);
    end else begin
      chk("sdo_partial", got, exp >> (8 - nbits));
    end
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < 200 && !rx_valid; t++) wclk(1);
      chk("rx_valid", rx_valid, 1'b1);
      if (rx_valid) begin
        e = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
        chk("rx_data", rx_data, e);
        rx_ready = 1'b1; wclk(1);
        rx_ready = 1'b0; wclk(1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; md = 2'b00; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_flags = 1'b0;
    wclk(3);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_sdo", sdo, 1'b0);
    chk("rst_sdo_oe", sdo_oe, 1'b0);
    chk("rst_tx_level", tx_level, 3'd0);
    chk("rst_rx_level", rx_level, 3'd0);
    chk("rst_flags", {rx_overflow, tx_underflow}, 2'b00);
    rst = 1'b0;
    wclk(5);

    // Mode 0 single word with latency check
    set_mode(2'b00);
    host_push(8'hA5);
    chk("tx_level_push", tx_level, 3'd1);
    cs_low();
    chk("sdo_oe_sel", sdo_oe, 1'b1);
    xfer(8'h3C, 8, 1'b1);
    cs_high();
    chk("tx_level_empty", tx_level, 3'd0);
    chk("sdo_desel", sdo, 1'b0);
    chk("sdo_oe_desel", sdo_oe, 1'b0);
    drain(1);

    // Modes 1..3, two back-to-back words per select
    for (int m = 1; m < 4; m++) begin
      set_mode(2'(m));
      host_push(8'h81);
      host_push(8'h7E);
      cs_low();
      xfer(8'h81, 8, 1'b0);
      xfer(8'h7E, 8, 1'b0);
      cs_high();
      drain(2);
    end

    // Overflow: five words with rx_ready low, the fifth is dropped
    set_mode(2'b00);
    pulse_clr();
    cs_low();
    for (int i = 0; i < 5; i++) xfer(8'(8'h11 * (i + 1)), 8, 1'b0);
    cs_high();
    void'(rxq.pop_back());
    chk("ovf_rx_level", rx_level, 3'd4);
    chk("ovf_flag", rx_overflow, 1'b1);
    pulse_clr();
    chk("ovf_cleared", rx_overflow, 1'b0);
    chk("unf_cleared", tx_underflow, 1'b0);
    drain(4);
    chk("ovf_drained", rx_level, 3'd0);

    // Underflow: empty tx FIFO sends TX_IDLE
    set_mode(2'b01);
    cs_low();
    chk("unf_before", tx_underflow, 1'b0);
    xfer(8'h5A, 8, 1'b0);
    chk("unf_set", tx_underflow, 1'b1);
    cs_high();
    drain(1);

    // Abort after 3 bits; popped word is lost, next word is clean
    set_mode(2'b00);
    host_push(8'hC3);
    cs_low();
    xfer(8'hFF, 3, 1'b0);
    cs_high();
    chk("abort_rx_valid", rx_valid, 1'b0);
    chk("abort_rx_level", rx_level, 3'd0);
    host_push(8'h96);
    cs_low();
    xfer(8'h69, 8, 1'b0);
    cs_high();
    drain(1);
    chk("abort_drained", rx_level, 3'd0);

    // Reset mid-word with two words still queued
    set_mode(2'b00);
    host_push(8'h01);
    host_push(8'h02);
    host_push(8'h03);
    chk("pre_rst_level3", tx_level, 3'd3);
    cs_low();
    chk("pre_rst_level2", tx_level, 3'd2);
    xfer(8'hF0, 3, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_level", tx_level, 3'd0);
    chk("mid_rst_rx_level", rx_level, 3'd0);
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_sdo", sdo, 1'b0);
    chk("mid_rst_sdo_oe", sdo_oe, 1'b0);
    chk("mid_rst_flags", {rx_overflow, tx_underflow}, 2'b00);
    wclk(2);
    rst = 1'b0;
    txq.delete();
    wclk(10);
    repeat (8) begin
      sck = ~md[1]; wclk(H);
      sck = md[1];  wclk(H);
    end
    wclk(8);
    chk("post_rst_rx_valid", rx_valid, 1'b0);
    chk("post_rst_sdo", sdo, 1'b0);
    cs_high();
    cs_low();
    xfer(8'hE7, 8, 1'b0);
    cs_high();
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
